// File: rtl/photocell_pulse_gen.sv
// photocell_pulse_gen
//
// Conditions the queue's front and back photocell beams: each raw (async)
// beam signal is synchronized through two flops, debounced, and turned into
// a single-cycle pulse per accepted beam break (0->1 of the debounced level).
// The two channels are fully independent and may pulse in the same cycle.
//
// Build macro PHOTOCELL_STUCK_DETECT_EN: when defined, each channel also
// flags a beam held blocked for STUCK_CYCLES cycles. When undefined, no stuck
// counters exist and front_stuck / back_stuck are constant 0.

module photocell_pulse_gen_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic pulse,
    output logic level,
    output logic stuck
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          level_nxt;

    // A new level is accepted on the edge where it has differed from the
    // stable level for DEBOUNCE_CYCLES consecutive synchronized samples.
    assign accept    = (s2 != level) && (cnt == CNT_LAST);
    assign level_nxt = accept ? s2 : level;

    // Two-flop synchronizer for the asynchronous beam input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce: count consecutive samples that disagree with the stable level;
    // any agreeing sample (a glitch ending) restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Registered pulse, high only in the cycle the level first becomes 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse <= 1'b0;
        end else begin
            pulse <= accept & s2;
        end
    end

`ifdef PHOTOCELL_STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] STK_MAX  = SW'(STUCK_CYCLES);
    localparam logic [SW-1:0] STK_LAST = SW'(STUCK_CYCLES - 1);

    logic [SW-1:0] stk_cnt;

    // Count cycles spent blocked; the flag and count drop in the same cycle
    // the debounced level returns to 0 (hence the look-ahead on level_nxt).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stk_cnt <= '0;
            stuck   <= 1'b0;
        end else if (!level_nxt) begin
            stk_cnt <= '0;
            stuck   <= 1'b0;
        end else if (level) begin
            if (stk_cnt != STK_MAX) begin
                stk_cnt <= stk_cnt + SW'(1);
            end
            if (stk_cnt == STK_LAST) begin
                stuck <= 1'b1;
            end
        end
    end
`else
    // No detector in this build. The parameter stays referenced so both builds
    // share one interface; the compare is constant 0 for any legal value.
    assign stuck = (STUCK_CYCLES < 0);
`endif

endmodule

module photocell_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic front_raw,
    input  logic back_raw,
    output logic front_photocell,
    output logic back_photocell,
    output logic front_level,
    output logic back_level,
    output logic front_stuck,
    output logic back_stuck
);

    photocell_pulse_gen_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_front (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (front_raw),
        .pulse   (front_photocell),
        .level   (front_level),
        .stuck   (front_stuck)
    );

    photocell_pulse_gen_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_back (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (back_raw),
        .pulse   (back_photocell),
        .level   (back_level),
        .stuck   (back_stuck)
    );

endmodule
